// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, 8N1 frame constants, bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  // Clock cycles per serial bit (truncating division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clear-able modulo-CLKS_PER_BIT counter; bit_done marks the last cycle of a bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned      CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  // Count 0..CLKS_PER_BIT-1, restarting on clear or wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  assign bit_done = (baud_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a one-byte holding register and TX_EN/TX_STATUS handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_status,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end

  uart_state_t state, state_next;
  logic [7:0]  shift, shift_next;
  logic [7:0]  hold, hold_next;
  logic        hold_valid, hold_valid_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic        txd_next;
  logic        bit_done;
  logic        baud_clear;

  // The counter idles at zero and restarts on every state change.
  assign baud_clear = (state == IDLE) || (state_next != state);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  assign tx_busy = (state != IDLE);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      bit_cnt    <= '0;
      tx_status  <= 1'b1;
      uart_txd   <= 1'b1;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      hold       <= hold_next;
      hold_valid <= hold_valid_next;
      bit_cnt    <= bit_cnt_next;
      tx_status  <= !hold_valid_next;
      uart_txd   <= txd_next;
    end
  end

  // Next-state, shift/hold bookkeeping and line level.
  always_comb begin
    state_next      = state;
    shift_next      = shift;
    hold_next       = hold;
    hold_valid_next = hold_valid;
    bit_cnt_next    = bit_cnt;
    txd_next        = 1'b1;

    unique case (state)
      IDLE: begin
        if (hold_valid) begin
          shift_next      = hold;
          hold_valid_next = 1'b0;
          state_next      = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next   = shift >> 1;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (hold_valid) begin
            shift_next      = hold;
            hold_valid_next = 1'b0;
            state_next      = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Accept cannot coincide with an unload: tx_status is low while hold is full.
    if (tx_en && tx_status) begin
      hold_next       = tx_data;
      hold_valid_next = 1'b1;
    end

    // Line level is derived from the next state so the registered pin
    // changes on the same edge as the FSM.
    unique case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at CLKS_PER_BIT = 8.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic       tx_busy;
  logic       uart_txd;

  int unsigned total;
  int unsigned bad;

  uart_tx #(
    .CLK_FREQ(80),
    .BAUD    (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_status(tx_status),
    .tx_busy  (tx_busy),
    .uart_txd (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle k (0..79) of a frame carrying b.
  function automatic logic frame_level(input logic [7:0] b, input int k);
    int idx;
    logic [7:0] v;
    v   = b;
    idx = k / 8;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return v[idx-1];
  endfunction

  task automatic frame_check(input logic [7:0] b, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      check($sformatf("frame_%02h_c%0d_txd", b, k), 32'(uart_txd), 32'(frame_level(b, k)));
      check($sformatf("frame_%02h_c%0d_busy", b, k), 32'(tx_busy), 32'd1);
      step();
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check($sformatf("%s_txd_%0d", tag, i), 32'(uart_txd), 32'd1);
      check($sformatf("%s_busy_%0d", tag, i), 32'(tx_busy), 32'd0);
      step();
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    tx_en   = 1'b0;
    tx_data = 8'h00;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_txd", 32'(uart_txd), 32'd1);
      check("rst_status", 32'(tx_status), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
    end
    reset = 1'b0;
    step();
    check("post_rst_txd", 32'(uart_txd), 32'd1);
    check("post_rst_status", 32'(tx_status), 32'd1);
    check("post_rst_busy", 32'(tx_busy), 32'd0);

    // Single byte 0xA5.
    tx_data = 8'hA5;
    tx_en   = 1'b1;
    step();                                   // N+1
    tx_en = 1'b0;
    check("a5_n1_status", 32'(tx_status), 32'd0);
    check("a5_n1_busy", 32'(tx_busy), 32'd0);
    check("a5_n1_txd", 32'(uart_txd), 32'd1);
    step();                                   // N+2
    check("a5_n2_status", 32'(tx_status), 32'd1);
    frame_check(8'hA5, 0, 79);                // ends at N+82
    check("a5_n82_busy", 32'(tx_busy), 32'd0);
    check("a5_n82_txd", 32'(uart_txd), 32'd1);
    idle_check("a5_idle", 4);

    // Queue while busy; third write blocked.
    tx_data = 8'h3C;
    tx_en   = 1'b1;
    step();                                   // N+1
    tx_en = 1'b0;
    check("q_n1_status", 32'(tx_status), 32'd0);
    step();                                   // N+2
    for (int i = 0; i < 3; i++) begin
      check("q_start_txd", 32'(uart_txd), 32'd0);
      step();
    end                                       // N+5
    check("q_n5_txd", 32'(uart_txd), 32'd0);
    check("q_n5_status", 32'(tx_status), 32'd1);
    tx_data = 8'hC3;
    tx_en   = 1'b1;
    step();                                   // N+6
    check("q_n6_txd", 32'(uart_txd), 32'd0);
    check("q_n6_status", 32'(tx_status), 32'd0);
    tx_data = 8'h77;
    step();                                   // N+7
    tx_en = 1'b0;
    frame_check(8'h3C, 5, 79);
    frame_check(8'hC3, 0, 79);
    check("q_end_status", 32'(tx_status), 32'd1);
    idle_check("q_idle", 100);

    // 0x11 accepted, 0x22 accepted once empty, 0x33 blocked.
    tx_data = 8'h11;
    tx_en   = 1'b1;
    step();                                   // M+1
    tx_en = 1'b0;
    check("f_m1_status", 32'(tx_status), 32'd0);
    step();                                   // M+2
    check("f_m2_status", 32'(tx_status), 32'd1);
    check("f_m2_txd", 32'(uart_txd), 32'd0);
    tx_data = 8'h22;
    tx_en   = 1'b1;
    step();                                   // M+3
    check("f_m3_status", 32'(tx_status), 32'd0);
    check("f_m3_txd", 32'(uart_txd), 32'd0);
    tx_data = 8'h33;
    step();                                   // M+4
    tx_en = 1'b0;
    frame_check(8'h11, 2, 79);
    frame_check(8'h22, 0, 79);
    idle_check("f_idle", 100);

    // Reset during data bit 4 of 0xFF with 0x00 queued.
    tx_data = 8'hFF;
    tx_en   = 1'b1;
    step();                                   // P+1
    tx_en = 1'b0;
    step();                                   // P+2, frame cycle 0
    check("r_p2_status", 32'(tx_status), 32'd1);
    check("r_p2_txd", 32'(uart_txd), 32'd0);
    tx_data = 8'h00;
    tx_en   = 1'b1;
    step();                                   // frame cycle 1
    tx_en = 1'b0;
    check("r_queued_status", 32'(tx_status), 32'd0);
    frame_check(8'hFF, 1, 43);                // now at frame cycle 44 (bit 4)
    reset = 1'b1;
    step();
    check("r_abort_txd", 32'(uart_txd), 32'd1);
    check("r_abort_status", 32'(tx_status), 32'd1);
    check("r_abort_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    step();
    idle_check("r_idle", 100);

    // Write during the final stop cycle with hold empty.
    tx_data = 8'h5A;
    tx_en   = 1'b1;
    step();
    tx_en = 1'b0;
    step();
    frame_check(8'h5A, 0, 78);                // now in final stop cycle
    check("s_last_txd", 32'(uart_txd), 32'd1);
    check("s_last_busy", 32'(tx_busy), 32'd1);
    check("s_last_status", 32'(tx_status), 32'd1);
    tx_data = 8'h96;
    tx_en   = 1'b1;
    step();                                   // +1: IDLE with hold full
    tx_en = 1'b0;
    check("s_p1_busy", 32'(tx_busy), 32'd0);
    check("s_p1_txd", 32'(uart_txd), 32'd1);
    check("s_p1_status", 32'(tx_status), 32'd0);
    step();                                   // +2: start bit
    frame_check(8'h96, 0, 79);
    check("s_end_busy", 32'(tx_busy), 32'd0);
    check("s_end_txd", 32'(uart_txd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
